// File: rtl/muxn_skid.sv
// muxn_skid
// Registered N-input, W-bit select multiplexer with a valid/ready handshake
// and a two-entry skid buffer (output register OUT plus one SKID register).
// Out-of-range selects emit the DEFAULT word, are flagged on O_sel_err and
// are counted in a saturating 8-bit error counter.
//
// Ports:
//   I_clk      clock, all state updates on the rising edge
//   I_rst_n    asynchronous active-low reset
//   I_sel      input select, sampled together with I_valid
//   I_data     flattened inputs, input k at bits [k*WIDTH +: WIDTH]
//   I_valid    upstream beat valid
//   O_ready    block can accept a beat this cycle (registered state only)
//   O_data     selected word, always taken from OUT
//   O_sel_err  current output beat came from an out-of-range select
//   O_valid    output beat valid
//   I_ready    downstream accepts the output beat
//   O_err_cnt  saturating count of accepted out-of-range beats
module muxn_skid #(
  parameter int               WIDTH   = 32,
  parameter int               NUM_IN  = 3,
  parameter logic [WIDTH-1:0] DEFAULT = '0,
  localparam int              SEL_W   = $clog2(NUM_IN)
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic [SEL_W-1:0]        I_sel,
  input  logic [NUM_IN*WIDTH-1:0] I_data,
  input  logic                    I_valid,
  output logic                    O_ready,
  output logic [WIDTH-1:0]        O_data,
  output logic                    O_sel_err,
  output logic                    O_valid,
  input  logic                    I_ready,
  output logic [7:0]              O_err_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic [7:0]       err_cnt;

  logic             sel_in_range;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] beat_data;
  logic             beat_err;
  logic             accept;
  logic             pop;

  // Handshake outputs decode registered state only, so there is no
  // combinational path from I_ready to O_ready.
  assign O_ready   = (state != FULL);
  assign O_valid   = (state != EMPTY);
  assign O_data    = out_data;
  assign O_sel_err = out_err;
  assign O_err_cnt = err_cnt;

  assign accept = I_valid & O_ready;
  assign pop    = O_valid & I_ready;

  // Select decode as a compare-per-input loop so an out-of-range select
  // never forms an out-of-bounds part-select; it falls back to DEFAULT.
  always_comb begin
    sel_in_range = (int'(I_sel) < NUM_IN);
    sel_word     = DEFAULT;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(I_sel) == k) sel_word = I_data[k*WIDTH +: WIDTH];
    end
    beat_data = sel_in_range ? sel_word : DEFAULT;
    beat_err  = ~sel_in_range;
  end

  // Storage FSM. OUT only changes on a pop or when empty, which keeps the
  // presented word stable while the downstream stalls. Accept cannot
  // happen in FULL because O_ready is low there.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data <= beat_data;
            out_err  <= beat_err;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_data <= beat_data;
            out_err  <= beat_err;
          end else if (accept) begin
            skid_data <= beat_data;
            skid_err  <= beat_err;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating error counter; it never wraps and only reset clears it.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      err_cnt <= 8'd0;
    end else if (accept && beat_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_muxn_skid.sv
// tb_muxn_skid
// Directed and scoreboard-driven bench for muxn_skid with the default
// parameters (WIDTH=32, NUM_IN=3). Inputs change and outputs are sampled
// 1 ns after each rising clock edge.
module tb_muxn_skid;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;

  logic                    I_clk;
  logic                    I_rst_n;
  logic [1:0]              I_sel;
  logic [NUM_IN*WIDTH-1:0] I_data;
  logic                    I_valid;
  logic                    O_ready;
  logic [WIDTH-1:0]        O_data;
  logic                    O_sel_err;
  logic                    O_valid;
  logic                    I_ready;
  logic [7:0]              O_err_cnt;

  int errors = 0;
  int checks = 0;

  muxn_skid #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_sel     (I_sel),
    .I_data    (I_data),
    .I_valid   (I_valid),
    .O_ready   (O_ready),
    .O_data    (O_data),
    .O_sel_err (O_sel_err),
    .O_valid   (O_valid),
    .I_ready   (I_ready),
    .O_err_cnt (O_err_cnt)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic test_reset();
    I_rst_n = 1'b0;
    I_valid = 1'b1;
    I_ready = 1'b1;
    I_sel   = 2'd1;
    I_data  = {NUM_IN{32'hDEADBEEF}};
    #12;
    checks++; if (O_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", O_valid); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", O_ready); end
    checks++; if (O_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", O_data); end
    checks++; if (O_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_err got=%b exp=0", O_sel_err); end
    checks++; if (O_err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt got=%0d exp=0", O_err_cnt); end
    I_valid = 1'b0;
    I_rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'h11111111;
    exp_words[1] = 32'h22222222;
    exp_words[2] = 32'h33333333;
    I_data  = {32'h33333333, 32'h22222222, 32'h11111111};
    I_ready = 1'b1;
    I_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      I_sel = 2'(i);
      step();
      checks++; if (O_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d] got=%b exp=1", i, O_valid); end
      checks++; if (O_data !== exp_words[i]) begin errors++; $display("[TB] FAIL basic_data[%0d] got=%h exp=%h", i, O_data, exp_words[i]); end
      checks++; if (O_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_sel_err[%0d] got=%b exp=0", i, O_sel_err); end
    end
    I_valid = 1'b0;
    step();
    checks++; if (O_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got=%b exp=0", O_valid); end
  endtask

  task automatic test_sel_err();
    I_data  = {NUM_IN{32'hFFFFFFFF}};
    I_sel   = 2'd3;
    I_valid = 1'b1;
    I_ready = 1'b1;
    step();
    I_valid = 1'b0;
    checks++; if (O_data !== 32'h0) begin errors++; $display("[TB] FAIL selerr_data got=%h exp=00000000", O_data); end
    checks++; if (O_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL selerr_flag got=%b exp=1", O_sel_err); end
    checks++; if (O_err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL selerr_cnt got=%0d exp=1", O_err_cnt); end
    step();
  endtask

  task automatic test_back_to_back();
    I_data  = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    I_ready = 1'b0;
    I_valid = 1'b1;
    I_sel   = 2'd0;
    step();
    checks++; if (O_data !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL stall_a_data got=%h exp=aaaaaaaa", O_data); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_one_ready got=%b exp=1", O_ready); end
    I_sel = 2'd1;
    step();
    I_valid = 1'b0;
    checks++; if (O_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_ready got=%b exp=0", O_ready); end
    checks++; if (O_data !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL stall_full_data got=%h exp=aaaaaaaa", O_data); end
    step();
    checks++; if (O_data !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL stall_hold_data got=%h exp=aaaaaaaa", O_data); end
    checks++; if (O_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold_valid got=%b exp=1", O_valid); end
    I_ready = 1'b1;
    step();
    checks++; if (O_data !== 32'hBBBBBBBB) begin errors++; $display("[TB] FAIL stall_b_data got=%h exp=bbbbbbbb", O_data); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_back got=%b exp=1", O_ready); end
    step();
    checks++; if (O_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_empty got=%b exp=0", O_valid); end
  endtask

  task automatic test_saturation();
    I_data  = {NUM_IN{32'h5A5A5A5A}};
    I_sel   = 2'd3;
    I_ready = 1'b1;
    I_valid = 1'b1;
    // Counter already holds 1 from the earlier out-of-range beat.
    for (int i = 0; i < 100; i++) step();
    checks++; if (O_err_cnt !== 8'd101) begin errors++; $display("[TB] FAIL sat_mid got=%0d exp=101", O_err_cnt); end
    for (int i = 0; i < 200; i++) step();
    checks++; if (O_err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_full got=%0d exp=255", O_err_cnt); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (O_err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold got=%0d exp=255", O_err_cnt); end
    I_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] beat;
    logic [1:0]  s;
    bit          acc;
    bit          pp;
    int          rnd_err = 0;
    for (int c = 0; c < 10000; c++) begin
      s       = 2'($urandom_range(3, 0));
      I_sel   = s;
      for (int k = 0; k < NUM_IN; k++) I_data[k*WIDTH +: WIDTH] = $urandom;
      I_valid = ($urandom_range(99, 0) < 60);
      I_ready = ($urandom_range(99, 0) < 55);
      acc = I_valid && (q.size() < 2);
      pp  = I_ready && (q.size() != 0);
      if (s < 2'd3) beat = {1'b0, I_data[s*WIDTH +: WIDTH]};
      else          beat = {1'b1, 32'h0};
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(beat);
      step();
      checks++;
      if (O_valid !== (q.size() != 0) || O_ready !== (q.size() < 2)) begin
        errors++;
        if (rnd_err < 10) $display("[TB] FAIL rnd_flags cyc=%0d got v=%b r=%b exp depth=%0d", c, O_valid, O_ready, q.size());
        rnd_err++;
      end
      if (q.size() != 0) begin
        checks++;
        if ({O_sel_err, O_data} !== q[0]) begin
          errors++;
          if (rnd_err < 10) $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", c, {O_sel_err, O_data}, q[0]);
          rnd_err++;
        end
      end
    end
    I_valid = 1'b0;
    I_ready = 1'b1;
    step();
    step();
    checks++; if (O_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_drain got=%b exp=0", O_valid); end
  endtask

  task automatic test_async_reset();
    I_data  = {32'h33333333, 32'h22222222, 32'h11111111};
    I_ready = 1'b0;
    I_valid = 1'b1;
    I_sel   = 2'd3;
    step();
    step();
    I_valid = 1'b0;
    checks++; if (O_ready !== 1'b0) begin errors++; $display("[TB] FAIL arst_full got=%b exp=0", O_ready); end
    #2;
    I_rst_n = 1'b0;
    #1;
    checks++; if (O_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid got=%b exp=0", O_valid); end
    checks++; if (O_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready got=%b exp=1", O_ready); end
    checks++; if (O_err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL arst_cnt got=%0d exp=0", O_err_cnt); end
    checks++; if (O_data !== 32'h0) begin errors++; $display("[TB] FAIL arst_data got=%h exp=0", O_data); end
    #2;
    I_rst_n = 1'b1;
    I_sel   = 2'd2;
    I_valid = 1'b1;
    I_ready = 1'b1;
    step();
    I_valid = 1'b0;
    checks++; if (O_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_resume_valid got=%b exp=1", O_valid); end
    checks++; if (O_data !== 32'h33333333) begin errors++; $display("[TB] FAIL arst_resume_data got=%h exp=33333333", O_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sel_err();
    test_back_to_back();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
